// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte to a PS/2 device over the open-collector CLK/DAT lines.
// Define PS2_TX_TIMEOUT_EN to build the watchdog that aborts a transfer when the device stops clocking.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1680,
    parameter int TIMEOUT_CYCLES = 280000
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       err_nack,
    output logic       err_timeout
);

    localparam int CNT_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           state_q;
    logic [1:0]       clk_sync_q;
    logic [1:0]       dat_sync_q;
    logic             clk_prev_q;
    logic [9:0]       sh_q;
    logic [3:0]       bitcnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             nack_q;
    logic             clk_oe_q;
    logic             dat_oe_q;
    logic             busy_q;
    logic             done_q;
    logic             err_nack_q;

    logic             clk_s;
    logic             dat_s;
    logic             fe;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0]  wd_q;
    logic             err_timeout_q;
`endif

    // Pins idle high, so the synchronisers reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, so the chain really delays.
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fe    = clk_prev_q & ~clk_s;

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q    <= S_IDLE;
            sh_q       <= '0;
            bitcnt_q   <= '0;
            cnt_q      <= '0;
            nack_q     <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_nack_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            err_nack_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            err_timeout_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    // busy_q is still set during the done cycle, which blocks a same-cycle restart.
                    if (tx_start && !busy_q) begin
                        sh_q     <= {1'b1, ~^tx_data, tx_data};
                        bitcnt_q <= '0;
                        cnt_q    <= '0;
                        nack_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        clk_oe_q <= 1'b1;
                        state_q  <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        dat_oe_q <= 1'b1;
                        state_q  <= S_REQ;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_REQ: begin
                    clk_oe_q <= 1'b0;
                    state_q  <= S_SEND;
                end

                S_SEND: begin
                    if (fe) begin
                        dat_oe_q <= ~sh_q[0];
                        sh_q     <= {1'b0, sh_q[9:1]};
                        bitcnt_q <= bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd9) begin
                            state_q <= S_ACK;
                        end
                    end
                end

                S_ACK: begin
                    if (fe) begin
                        nack_q  <= dat_s;
                        state_q <= S_WAIT_IDLE;
                    end
                end

                S_WAIT_IDLE: begin
                    if (clk_s && dat_s) begin
                        clk_oe_q   <= 1'b0;
                        dat_oe_q   <= 1'b0;
                        done_q     <= 1'b1;
                        err_nack_q <= nack_q;
                        state_q    <= S_IDLE;
                    end
                end

                default: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase

`ifdef PS2_TX_TIMEOUT_EN
            // Placed after the case so an expired watchdog overrides the normal transition.
            if (state_q == S_REQ || fe) begin
                wd_q <= '0;
            end else if (state_q inside {S_SEND, S_ACK, S_WAIT_IDLE}) begin
                wd_q <= wd_q + WD_W'(1);
                if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    clk_oe_q      <= 1'b0;
                    dat_oe_q      <= 1'b0;
                    done_q        <= 1'b1;
                    err_nack_q    <= 1'b0;
                    err_timeout_q <= 1'b1;
                    state_q       <= S_IDLE;
                end
            end
`endif
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_nack   = err_nack_q;

`ifdef PS2_TX_TIMEOUT_EN
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model on wired-AND lines.
// Define PS2_TX_TIMEOUT_EN for both files to include the watchdog scenario.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 400;
    localparam int HALF    = 40;

    logic        clk      = 1'b0;
    logic        nreset   = 1'b0;
    logic [7:0]  tx_data  = 8'h00;
    logic        tx_start = 1'b0;
    logic        dev_clk  = 1'b1;
    logic        dev_dat  = 1'b1;
    logic        ps2_clk_pin;
    logic        ps2_dat_pin;
    logic        ps2_clk_oe;
    logic        ps2_dat_oe;
    logic        busy;
    logic        done;
    logic        err_nack;
    logic        err_timeout;

    int          checks    = 0;
    int          failures  = 0;
    int          done_seen = 0;
    int          done_ref  = 0;

    logic [10:0] bits;
    logic        got_done;
    int          waited;
    logic        nack_at_done;
    logic        tout_at_done;
    logic        busy_at_done;
    logic [1:0]  oe_at_done;
    int          inh_len;
    logic        dat_in_inhibit;
    logic        dat_in_req;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK        (clk),
        .nRESET     (nreset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .ps2_clk_in (ps2_clk_pin),
        .ps2_dat_in (ps2_dat_pin),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .err_nack   (err_nack),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Open-collector lines: either side pulling low wins.
    assign ps2_clk_pin = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_pin = dev_dat & ~ps2_dat_oe;

    always @(posedge clk) begin
        if (done) done_seen <= done_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the first negedge after tx_start was sampled.
    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic measure_inhibit();
        inh_len        = 0;
        dat_in_inhibit = 1'bx;
        dat_in_req     = 1'bx;
        while (ps2_clk_oe && inh_len < 5000) begin
            inh_len++;
            if (inh_len == INHIBIT) dat_in_inhibit = ps2_dat_oe;
            dat_in_req = ps2_dat_oe;
            @(negedge clk);
        end
    endtask

    // Device model: the host's clock release is the first rising edge (start bit),
    // then nclk device clocks; bits are captured on each rising edge.
    task automatic run_xfer(input int nclk, input logic ack);
        bits = 'x;
        for (int i = 0; i < 5000 && ps2_clk_oe; i++) @(negedge clk);
        bits[0] = ps2_dat_pin;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            if (i == 10 && ack) begin
                dev_dat = 1'b0;
                repeat (5) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (i < 10) bits[i+1] = ps2_dat_pin;
            if (i == 10) begin
                dev_dat = 1'b1;
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic wait_done(input int limit);
        got_done     = 1'b0;
        waited       = 0;
        nack_at_done = 1'bx;
        tout_at_done = 1'bx;
        busy_at_done = 1'bx;
        oe_at_done   = 2'bxx;
        while (!got_done && waited < limit) begin
            @(negedge clk);
            waited++;
            if (done) begin
                got_done     = 1'b1;
                nack_at_done = err_nack;
                tout_at_done = err_timeout;
                busy_at_done = busy;
                oe_at_done   = {ps2_clk_oe, ps2_dat_oe};
            end
        end
    endtask

    task automatic do_frame(input string tag, input logic [10:0] exp, input logic ack);
        run_xfer(11, ack);
        check({tag, "_frame"}, bits, exp);
        wait_done(50);
        check({tag, "_done"}, got_done, 1);
        check({tag, "_done_latency"}, waited, 3);
        check({tag, "_err_nack"}, nack_at_done, !ack);
        check({tag, "_err_timeout"}, tout_at_done, 0);
        check({tag, "_busy_at_done"}, busy_at_done, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {ps2_clk_oe, ps2_dat_oe, busy, done, err_nack, err_timeout}, 6'b0);
        nreset = 1'b1;
        @(negedge clk);
        check("idle_outputs", {ps2_clk_oe, ps2_dat_oe, busy, done, err_nack, err_timeout}, 6'b0);

        // 0xED: D0..D7 = 1,0,1,1,0,1,1,1, six ones -> parity 1.
        start_tx(8'hED);
        check("start_busy_clkoe", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b110);
        measure_inhibit();
        check("clk_oe_len", inh_len, INHIBIT + 1);
        check("inhibit_dat_released", dat_in_inhibit, 0);
        check("req_dat_low", dat_in_req, 1);
        do_frame("ed", {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1);

        // Start held across the done cycle: ignored there, accepted one cycle later.
        tx_data  = 8'h01;
        tx_start = 1'b1;
        @(negedge clk);
        check("start_in_done_ignored", {busy, ps2_clk_oe, done}, 3'b000);
        @(negedge clk);
        check("start_after_done_taken", {busy, ps2_clk_oe}, 2'b11);
        tx_start = 1'b0;
        do_frame("x01", {1'b1, 1'b0, 8'h01, 1'b0}, 1'b1);

        repeat (10) @(negedge clk);
        start_tx(8'h00);
        do_frame("x00", {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1);

        // 0xF4 has five ones -> parity 0; device withholds the ACK.
        repeat (10) @(negedge clk);
        start_tx(8'hF4);
        do_frame("nack", {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b0);

        // A second request during a transfer must vanish.
        repeat (10) @(negedge clk);
        done_ref = done_seen;
        start_tx(8'hFF);
        repeat (5) @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        do_frame("ff", {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1);
        repeat (300) @(negedge clk);
        check("ff_single_done", done_seen - done_ref, 1);
        check("ff_no_requeue", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);

        // 0xA5: D0..D4 = 1,0,1,0,0; after five device clocks D4=0 is being driven.
        repeat (10) @(negedge clk);
        done_ref = done_seen;
        start_tx(8'hA5);
        run_xfer(5, 1'b0);
        check("mid_partial_bits", bits[5:0], 6'b001010);
        check("mid_bit5_state", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b101);
        nreset = 1'b0;
        @(negedge clk);
        check("mid_reset_release", {busy, ps2_clk_oe, ps2_dat_oe, done}, 4'b0000);
        nreset = 1'b1;
        repeat (300) @(negedge clk);
        check("mid_reset_no_done", done_seen - done_ref, 0);
        check("mid_reset_idle", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);

`ifdef PS2_TX_TIMEOUT_EN
        // Device stops after its 4th falling edge; that edge is registered 3 negedges later.
        repeat (10) @(negedge clk);
        start_tx(8'h3C);
        run_xfer(3, 1'b0);
        dev_clk = 1'b0;
        wait_done(TIMEOUT + 50);
        check("tout_done", got_done, 1);
        check("tout_latency", waited, TIMEOUT + 3);
        check("tout_err_timeout", tout_at_done, 1);
        check("tout_err_nack", nack_at_done, 0);
        check("tout_oe_released", oe_at_done, 2'b00);
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);
        check("tout_idle", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: observed=expired expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
